axi_lite_sram_slave: RTL and testbench
======================================

Name: axi_lite_sram_slave

Overview:
- AXI4-Lite-subset memory slave sitting directly downstream of the core's load/store unit; it answers the LSU's AR/R/AW/W/B channels.
- Single-port word array with a fixed, parameterised access latency and one outstanding transaction at a time.
- Sub-word data is lane-aligned to bit 0:
  - Reads return the addressed byte/half in the low lanes.
  - Write data and strobe arrive low-lane-aligned and are shifted by addr[1:0].

Parameters:
- BASE, 32'h8000_0000, byte address of word 0
- DEPTH, 65536, number of 32-bit words (power of two)
- LAT, 2, extra wait cycles before rvalid/bvalid (0..15)
- INIT_FILE, "", hex image loaded at elaboration when non-empty

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- araddr  in  32  read byte address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data, lane-aligned to bit 0
- rresp  out  2  00 OKAY, 11 DECERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data, lane-aligned to bit 0
- wstrb  in  4  byte strobes, lane-aligned to bit 0
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  00 OKAY, 11 DECERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - arready, awready, wready, rvalid and bvalid = 0; rdata = 0; rresp and bresp = 00.
  - Memory contents are preserved.
  - Any in-flight transaction is dropped without a response.
- First rising edge after reset release: arready=1, awready=1.
- States: IDLE, R_WAIT, R_RESP, W_DATA, W_WAIT, B_RESP.
- IDLE:
  - AR handshake (arvalid&arready): latch araddr; arready<=0 and awready<=0; counter<=LAT.
    - LAT=0: go to R_RESP with rvalid<=1 at that edge.
    - Otherwise go to R_WAIT.
  - AW handshake: latch awaddr; arready<=0, awready<=0, wready<=1; go to W_DATA.
  - arvalid and awvalid both high in the same cycle: read wins. awready is forced 0 in that cycle (combinationally gated by arvalid), so the AW stays pending.
- R_WAIT:
  - Counter decrements each edge.
  - At 1->0: rvalid<=1, rdata and rresp loaded; go to R_RESP.
  - Net timing: rvalid is first high LAT+1 cycles after the AR handshake cycle.
- R_RESP:
  - rdata and rresp are held stable while rvalid=1 and rready=0.
  - On rready: rvalid<=0, arready<=1, awready<=1; go to IDLE.
- W_DATA:
  - wready=1.
  - On wvalid: memory written at this edge; wready<=0; counter<=LAT.
    - LAT=0: go to B_RESP with bvalid<=1.
    - Otherwise go to W_WAIT.
- W_WAIT: counter decrements; at 1->0: bvalid<=1; go to B_RESP.
- B_RESP: on bready: bvalid<=0, arready<=1, awready<=1; go to IDLE.
- Address decode:
  - offset = addr - BASE; in range iff offset < DEPTH*4 (unsigned, so addresses below BASE wrap and are out of range).
  - Word index = offset[log2(DEPTH)+1:2]; byte offset a = addr[1:0].
- Read data: rdata = mem[idx] >> (8*a), zero-filled; the LSU extends it.
- Write: for each byte lane i with i>=a, if wstrb[i-a]=1 then lane i <= wdata[8*(i-a)+:8]. Strobe bits shifted past lane 3 are discarded; no cross-word writes.
- Out of range:
  - Read: rresp=11, rdata=0.
  - Write: bresp=11, memory unchanged.
  - Same latency as an in-range access.
- Never more than one transaction outstanding; arready and awready are 0 whenever the state is not IDLE.

Decomposition:
- Shared package axi_lite_pkg holds:
  - RESP_OKAY=2'b00 and RESP_DECERR=2'b11.
  - The six-state slave state enum (3-bit).
  - Strobe constants STRB_B=4'b0001, STRB_H=4'b0011, STRB_W=4'b1111, shared with the LSU.
- One sub-module, sram_lane_align (combinational), performs:
  - the read right-shift;
  - the write-data/strobe left-shift and byte merge from (word, a, wdata, wstrb).
- The FSM, counter and array stay in the top.

Test Plan:
- Reset and read after write:
  - Hold reset=0 for 3 cycles -> all valid/ready outputs 0.
  - Release -> arready=awready=1 after the first edge.
  - Write 32'hDEADBEEF to 0x8000_0010 with wstrb=1111, LAT=2 -> bvalid 3 cycles after the W handshake, bresp=00.
  - Read the same address -> rdata=DEADBEEF.
- Sub-word write and read:
  - Write wdata=32'h0000_ABCD, wstrb=0011 to 0x8000_0012 -> word at 0x8000_0010 = ABCDBEEF.
  - Byte read at 0x8000_0013 -> rdata=32'h0000_00AB.
- Collision and back-pressure:
  - arvalid and awvalid rise together -> read completes first and awready stays 0 until R_RESP exits; then the write proceeds.
  - Hold rready=0 for 5 cycles -> rvalid and rdata stay stable throughout.
- Decode error: read 0x7FFF_FFFC and write 0x8004_0000 (DEPTH=65536) -> rresp=11 with rdata=0, bresp=11, memory unchanged.
- Reset mid-operation: assert reset=0 in W_WAIT and in R_RESP -> bvalid/rvalid drop immediately; the data written at the W handshake is still readable afterwards.
- LAT=0 build: rvalid is high the cycle after the AR handshake and bvalid the cycle after the W handshake.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants for the LSU-facing slave: response codes, strobe shapes
// and the slave state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_R_WAIT = 3'd1,
        ST_R_RESP = 3'd2,
        ST_W_DATA = 3'd3,
        ST_W_WAIT = 3'd4,
        ST_B_RESP = 3'd5
    } slv_state_e;

endpackage

// File: rtl/sram_lane_align.sv
// Byte-lane steering between the low-lane-aligned LSU view and the stored word:
// read right-shift and write strobe/data left-shift with byte merge.
module sram_lane_align (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_ofs,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wword
);

    logic [31:0] w_data_sh;
    logic [3:0]  w_strb_sh;

    always_comb begin
        o_rdata   = i_word >> {i_ofs, 3'b000};
        w_data_sh = i_wdata << {i_ofs, 3'b000};
        // Strobe bits pushed past lane 3 fall off: no cross-word writes.
        w_strb_sh = i_wstrb << i_ofs;
        for (int i = 0; i < 4; i++) begin
            o_wword[8*i +: 8] = w_strb_sh[i] ? w_data_sh[8*i +: 8] : i_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite-subset SRAM slave behind the LSU: one outstanding transaction,
// fixed LAT wait cycles before each response, out-of-range accesses answer DECERR.
//
// state     | meaning
// ST_IDLE   | ready for AR or AW (AR wins a tie)
// ST_R_WAIT | read latency countdown
// ST_R_RESP | rvalid high, waiting for rready
// ST_W_DATA | address taken, wready high, waiting for wvalid
// ST_W_WAIT | write latency countdown
// ST_B_RESP | bvalid high, waiting for bready
module axi_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int          DEPTH     = 65536,
    parameter int          LAT       = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  LAT_C = 4'(LAT);

    slv_state_e r_state, w_state_nxt;

    logic [31:0]   r_mem [0:DEPTH-1];
    logic [AW-1:0] r_idx;
    logic [1:0]    r_ofs;
    logic          r_ok;
    logic [3:0]    r_cnt;
    logic          r_live;
    logic [31:0]   r_rdata;
    logic [1:0]    r_rresp;
    logic [1:0]    r_bresp;

    logic          w_idle_rdy;
    logic          w_ar_hs, w_aw_hs, w_w_hs, w_load_r;
    logic [31:0]   w_sel_addr, w_ofs_full;
    logic          w_new_ok, w_cur_ok;
    logic [AW-1:0] w_cur_idx;
    logic [1:0]    w_cur_ofs;
    logic [31:0]   w_rd_shift, w_wword;

    // Incoming address is decoded in IDLE so a LAT=0 read can answer at the handshake edge.
    always_comb begin
        w_sel_addr = arvalid ? araddr : awaddr;
        w_ofs_full = w_sel_addr - BASE;
        w_new_ok   = {1'b0, w_ofs_full} < LIMIT;
        w_cur_idx  = (r_state == ST_IDLE) ? w_ofs_full[AW+1:2] : r_idx;
        w_cur_ofs  = (r_state == ST_IDLE) ? w_sel_addr[1:0] : r_ofs;
        w_cur_ok   = (r_state == ST_IDLE) ? w_new_ok : r_ok;
        w_ar_hs    = arvalid && arready;
        w_aw_hs    = awvalid && awready;
        w_w_hs     = (r_state == ST_W_DATA) && wvalid;
        w_load_r   = ((r_state == ST_R_WAIT) && (r_cnt == 4'd1)) || ((LAT == 0) && w_ar_hs);
    end

    sram_lane_align u_align (
        .i_word  (r_mem[w_cur_idx]),
        .i_ofs   (w_cur_ofs),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .o_rdata (w_rd_shift),
        .o_wword (w_wword)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ar_hs)      w_state_nxt = (LAT == 0) ? ST_R_RESP : ST_R_WAIT;
                else if (w_aw_hs) w_state_nxt = ST_W_DATA;
            end
            ST_R_WAIT: if (r_cnt == 4'd1) w_state_nxt = ST_R_RESP;
            ST_R_RESP: if (rready)        w_state_nxt = ST_IDLE;
            ST_W_DATA: if (wvalid)        w_state_nxt = (LAT == 0) ? ST_B_RESP : ST_W_WAIT;
            ST_W_WAIT: if (r_cnt == 4'd1) w_state_nxt = ST_B_RESP;
            ST_B_RESP: if (bready)        w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idle_rdy = (r_state == ST_IDLE) && r_live;
        arready    = w_idle_rdy;
        awready    = w_idle_rdy && !arvalid;
        wready     = (r_state == ST_W_DATA);
        rvalid     = (r_state == ST_R_RESP);
        bvalid     = (r_state == ST_B_RESP);
        rdata      = r_rdata;
        rresp      = r_rresp;
        bresp      = r_bresp;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_live  <= 1'b0;
            r_idx   <= '0;
            r_ofs   <= 2'b00;
            r_ok    <= 1'b0;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_rresp <= RESP_OKAY;
            r_bresp <= RESP_OKAY;
        end else begin
            r_live <= 1'b1;
            if (w_ar_hs || w_aw_hs) begin
                r_idx <= w_cur_idx;
                r_ofs <= w_cur_ofs;
                r_ok  <= w_cur_ok;
                r_cnt <= LAT_C;
            end else if (w_w_hs) begin
                r_cnt   <= LAT_C;
                r_bresp <= r_ok ? RESP_OKAY : RESP_DECERR;
            end else if ((r_state == ST_R_WAIT) || (r_state == ST_W_WAIT)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_load_r) begin
                r_rdata <= w_cur_ok ? w_rd_shift : 32'd0;
                r_rresp <= w_cur_ok ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    // Array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (w_w_hs && r_ok) r_mem[r_idx] <= w_wword;
    end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Bench for axi_lite_sram_slave: a LAT=2 and a LAT=0 instance share all inputs and are
// checked against table vectors and a response scoreboard.
module tb_axi_lite_sram_slave;
    import axi_lite_pkg::*;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
    logic        rready = 1'b1, bready = 1'b1;

    logic        arready, awready, wready, rvalid, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        arready_0, awready_0, wready_0, rvalid_0, bvalid_0;
    logic [31:0] rdata_0;
    logic [1:0]  rresp_0, bresp_0;

    int errors = 0;
    int checks = 0;
    bit aw_block = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[19];

    always #5 clock = ~clock;

    axi_lite_sram_slave #(.LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi_lite_sram_slave #(.LAT(0)) dut0 (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready_0),
        .rdata(rdata_0), .rresp(rresp_0), .rvalid(rvalid_0), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready_0),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_0),
        .bresp(bresp_0), .bvalid(bvalid_0), .bready(bready)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // While a read holds the slave, a pending AW must not see awready.
    always @(negedge clock) begin
        if (aw_block) begin
            checks++;
            if (awready !== 1'b0) begin
                errors++;
                $display("FAIL aw_blocked: awready=%b, expected 0", awready);
            end
        end
    end

    task automatic wait_ready(input bit is_aw, input bit is_w, output bit hs);
        int n = 0;
        hs = 1'b0;
        do begin
            @(negedge clock);
            hs = is_aw ? awready : (is_w ? wready : arready);
            n++;
            @(posedge clock);
            #1;
        end while (!hs && n < 50);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er,
                           input int hold, input bit abort);
        exp_t e;
        bit hs, seen0;
        int n, n0;
        logic [31:0] d0;
        logic [1:0]  r0;
        sb_q.push_back('{ed, er});
        rready  = (hold == 0);
        araddr  = addr;
        arvalid = 1'b1;
        wait_ready(1'b0, 1'b0, hs);
        arvalid = 1'b0;
        check32("ar_handshake", 32'(hs), 32'd1);
        n = 0; n0 = 0; seen0 = 1'b0; d0 = '0; r0 = '0;
        while (n < 50) begin
            @(negedge clock);
            n++;
            if (!seen0 && rvalid_0) begin
                seen0 = 1'b1; n0 = n; d0 = rdata_0; r0 = rresp_0;
            end
            if (rvalid) break;
        end
        e = sb_q.pop_front();
        check32("r_latency", 32'(n), 32'(LAT + 1));
        check32("r_data", rdata, e.data);
        check32("r_resp", 32'(rresp), 32'(e.resp));
        check32("r_latency_lat0", 32'(n0), 32'd1);
        check32("r_data_lat0", d0, e.data);
        check32("r_resp_lat0", 32'(r0), 32'(e.resp));
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            check32("r_hold_valid", 32'(rvalid), 32'd1);
            check32("r_hold_data", rdata, e.data);
        end
        rready = 1'b1;
        if (abort) begin
            reset = 1'b0;
            #1;
            check32("r_abort_rvalid", 32'(rvalid), 32'd0);
            check32("r_abort_rdata", rdata, 32'd0);
            check32("r_abort_arready", 32'(arready), 32'd0);
            release_reset();
        end else begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                            input logic [1:0] er, input bit abort);
        exp_t e;
        bit hs, seen0;
        int n, n0;
        logic [1:0] r0;
        sb_q.push_back('{32'd0, er});
        bready  = 1'b1;
        awaddr  = addr;
        awvalid = 1'b1;
        wait_ready(1'b1, 1'b0, hs);
        awvalid = 1'b0;
        check32("aw_handshake", 32'(hs), 32'd1);
        wdata  = wd;
        wstrb  = ws;
        wvalid = 1'b1;
        wait_ready(1'b0, 1'b1, hs);
        wvalid = 1'b0;
        check32("w_handshake", 32'(hs), 32'd1);
        e = sb_q.pop_front();
        if (abort) begin
            reset = 1'b0;
            #1;
            check32("w_abort_bvalid", 32'(bvalid), 32'd0);
            check32("w_abort_bvalid_lat0", 32'(bvalid_0), 32'd0);
            check32("w_abort_awready", 32'(awready), 32'd0);
            release_reset();
            return;
        end
        n = 0; n0 = 0; seen0 = 1'b0; r0 = '0;
        while (n < 50) begin
            @(negedge clock);
            n++;
            if (!seen0 && bvalid_0) begin
                seen0 = 1'b1; n0 = n; r0 = bresp_0;
            end
            if (bvalid) break;
        end
        check32("b_latency", 32'(n), 32'(LAT + 1));
        check32("b_resp", 32'(bresp), 32'(e.resp));
        check32("b_latency_lat0", 32'(n0), 32'd1);
        check32("b_resp_lat0", 32'(r0), 32'(e.resp));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, STRB_W, 32'h0,         RESP_OKAY};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0,   32'hDEAD_BEEF, RESP_OKAY};
        vecs[2]  = '{1'b1, 32'h8000_0012, 32'h0000_ABCD, STRB_H, 32'h0,         RESP_OKAY};
        vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0,   32'hABCD_BEEF, RESP_OKAY};
        vecs[4]  = '{1'b0, 32'h8000_0013, 32'h0,         4'h0,   32'h0000_00AB, RESP_OKAY};
        vecs[5]  = '{1'b0, 32'h8000_0012, 32'h0,         4'h0,   32'h0000_ABCD, RESP_OKAY};
        vecs[6]  = '{1'b0, 32'h8000_0011, 32'h0,         4'h0,   32'h00AB_CDBE, RESP_OKAY};
        vecs[7]  = '{1'b1, 32'h8000_0013, 32'h1122_3344, STRB_W, 32'h0,         RESP_OKAY};
        vecs[8]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0,   32'h44CD_BEEF, RESP_OKAY};
        vecs[9]  = '{1'b1, 32'h8000_0020, 32'h1234_5678, STRB_W, 32'h0,         RESP_OKAY};
        vecs[10] = '{1'b1, 32'h8000_0021, 32'h0000_00AA, STRB_B, 32'h0,         RESP_OKAY};
        vecs[11] = '{1'b0, 32'h8000_0020, 32'h0,         4'h0,   32'h1234_AA78, RESP_OKAY};
        vecs[12] = '{1'b1, 32'h8000_0000, 32'h0102_0304, STRB_W, 32'h0,         RESP_OKAY};
        vecs[13] = '{1'b1, 32'h8003_FFFC, 32'hCAFE_F00D, STRB_W, 32'h0,         RESP_OKAY};
        vecs[14] = '{1'b0, 32'h8003_FFFC, 32'h0,         4'h0,   32'hCAFE_F00D, RESP_OKAY};
        vecs[15] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0,   32'h0,         RESP_DECERR};
        vecs[16] = '{1'b1, 32'h8004_0000, 32'hFFFF_FFFF, STRB_W, 32'h0,         RESP_DECERR};
        vecs[17] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0,   32'h0102_0304, RESP_OKAY};
        vecs[18] = '{1'b0, 32'h8003_FFFE, 32'h0,         4'h0,   32'h0000_CAFE, RESP_OKAY};

        repeat (3) @(negedge clock);
        check32("reset_outputs", {27'd0, arready, awready, wready, rvalid, bvalid}, 32'd0);
        check32("reset_rdata", rdata, 32'd0);
        check32("reset_resp", {28'd0, rresp, bresp}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check32("ready_before_edge", {30'd0, arready, awready}, 32'd0);
        @(posedge clock);
        #1;
        check32("ready_after_edge", {30'd0, arready, awready}, 32'h3);
        check32("ready_after_edge_lat0", {30'd0, arready_0, awready_0}, 32'h3);

        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].exp_resp, 1'b0);
            else            do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, 0, 1'b0);
        end

        // Read and write arrive together: read first, write stays pending.
        awaddr   = 32'h8000_0040;
        awvalid  = 1'b1;
        aw_block = 1'b1;
        do_read(32'h8000_0010, 32'h44CD_BEEF, RESP_OKAY, 0, 1'b0);
        aw_block = 1'b0;
        do_write(32'h8000_0040, 32'h0BAD_CAFE, STRB_W, RESP_OKAY, 1'b0);
        do_read(32'h8000_0040, 32'h0BAD_CAFE, RESP_OKAY, 0, 1'b0);

        do_read(32'h8000_0020, 32'h1234_AA78, RESP_OKAY, 5, 1'b0);

        do_write(32'h8000_0030, 32'h5A5A_5A5A, STRB_W, RESP_OKAY, 1'b1);
        do_read(32'h8000_0030, 32'h5A5A_5A5A, RESP_OKAY, 0, 1'b0);
        do_read(32'h8000_0030, 32'h5A5A_5A5A, RESP_OKAY, 0, 1'b1);
        do_read(32'h8000_0010, 32'h44CD_BEEF, RESP_OKAY, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
